vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_pkg.sv | 35 +++
 rtl/vga_sync_delay.sv | 45 ++++
 rtl/vga_timing_gen.sv | 152 +++++++++++++++
 tb/tb_vga_timing_gen.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants for the 640x480@60 Hz raster generator.
package vga_timing_pkg;

  localparam int unsigned COORD_W     = 10;
  localparam int unsigned FRAME_CNT_W = 16;

  typedef logic [COORD_W-1:0] coord_t;
  // One extra bit so sync/visible bounds up to 1024 compare without overflow.
  typedef logic [COORD_W:0]   coord_ext_t;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FP_DEF      = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BP_DEF      = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FP_DEF      = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BP_DEF      = 33;

  localparam int unsigned SYNC_DELAY_MAX = 4;

  // Both syncs are active low on the VGA connector.
  localparam logic SYNC_ACTIVE = 1'b0;

  function automatic int unsigned h_total(input int unsigned vis, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return vis + fp + sync + bp;
  endfunction

  function automatic int unsigned v_total(input int unsigned vis, input int unsigned fp,
                                          input int unsigned sync, input int unsigned bp);
    return vis + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Shift register for the sync lines; every stage resets to 1 so that no
// spurious (active-low) sync pulse leaves the pipeline after reset.
module vga_sync_delay #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  if (Depth == 0) begin : gen_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk_i ^ rst_ni;
    assign q_o = d_i;
  end else begin : gen_pipe
    logic [Width-1:0] stage_q [Depth];
    logic [Width-1:0] stage_d [Depth];

    // Next state: each stage takes its predecessor, stage 0 takes the input.
    always_comb begin
      stage_d[0] = d_i;
      for (int i = 1; i < int'(Depth); i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    // Pipeline registers, filled with the idle (deasserted) level on reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < int'(Depth); i++) begin
          stage_q[i] <= '1;
        end
      end else begin
        for (int i = 0; i < int'(Depth); i++) begin
          stage_q[i] <= stage_d[i];
        end
      end
    end

    assign q_o = stage_q[Depth-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: pixel/line counters, blank, line/frame
// start pulses and active-low hs/vs delayed by SYNC_DELAY clocks.
// Optional feature macro: VGA_FRAME_CNT_EN adds a 16-bit frame counter port.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE  = H_VISIBLE_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_VISIBLE  = V_VISIBLE_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic               vga_clk,
  input  logic               reset_n,
  output logic [COORD_W-1:0] DrawX,
  output logic [COORD_W-1:0] DrawY,
  output logic               blank,
  output logic               hs,
  output logic               vs,
`ifdef VGA_FRAME_CNT_EN
  output logic [FRAME_CNT_W-1:0] frame_cnt,
`endif
  output logic               line_start,
  output logic               frame_start
);

  localparam int unsigned HTotal = h_total(H_VISIBLE, H_FP, H_SYNC, H_BP);
  localparam int unsigned VTotal = v_total(V_VISIBLE, V_FP, V_SYNC, V_BP);

  if (HTotal > (1 << COORD_W) || VTotal > (1 << COORD_W)) begin : gen_bad_total
    $error("vga_timing_gen: H/V total exceeds the coordinate counter range");
  end
  if (SYNC_DELAY > SYNC_DELAY_MAX) begin : gen_bad_delay
    $error("vga_timing_gen: SYNC_DELAY out of range");
  end

  localparam coord_t     HLast      = coord_t'(HTotal - 1);
  localparam coord_t     VLast      = coord_t'(VTotal - 1);
  localparam coord_ext_t HVis       = coord_ext_t'(H_VISIBLE);
  localparam coord_ext_t VVis       = coord_ext_t'(V_VISIBLE);
  localparam coord_ext_t HSyncStart = coord_ext_t'(H_VISIBLE + H_FP);
  localparam coord_ext_t HSyncEnd   = coord_ext_t'(H_VISIBLE + H_FP + H_SYNC);
  localparam coord_ext_t VSyncStart = coord_ext_t'(V_VISIBLE + V_FP);
  localparam coord_ext_t VSyncEnd   = coord_ext_t'(V_VISIBLE + V_FP + V_SYNC);

  // hc_q/vc_q are the presented position; DrawX/DrawY come straight from them.
  coord_t hc_q, hc_d;
  coord_t vc_q, vc_d;
  logic   primed_q, primed_d;
  logic   blank_q, blank_d;
  logic   line_start_q, line_start_d;
  logic   frame_start_q, frame_start_d;
  logic   hs_raw_q, hs_raw_d;
  logic   vs_raw_q, vs_raw_d;
  logic   in_hsync, in_vsync;
  logic [1:0] sync_dly;

  // Next position plus every output decoded from that same position, so all
  // registered outputs describe one pixel in the same cycle.
  always_comb begin
    primed_d = 1'b1;
    hc_d     = hc_q;
    vc_d     = vc_q;
    if (!primed_q) begin
      // First edge after reset presents (0,0) without advancing.
      hc_d = '0;
      vc_d = '0;
    end else if (hc_q == HLast) begin
      hc_d = '0;
      vc_d = (vc_q == VLast) ? '0 : vc_q + 1'b1;
    end else begin
      hc_d = hc_q + 1'b1;
    end

    blank_d       = ({1'b0, hc_d} < HVis) && ({1'b0, vc_d} < VVis);
    line_start_d  = (hc_d == '0);
    frame_start_d = (hc_d == '0) && (vc_d == '0);
    in_hsync      = ({1'b0, hc_d} >= HSyncStart) && ({1'b0, hc_d} < HSyncEnd);
    in_vsync      = ({1'b0, vc_d} >= VSyncStart) && ({1'b0, vc_d} < VSyncEnd);
    hs_raw_d      = in_hsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_raw_d      = in_vsync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
  end

  // Raster state and registered outputs.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      primed_q      <= 1'b0;
      hc_q          <= '0;
      vc_q          <= '0;
      blank_q       <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      hs_raw_q      <= ~SYNC_ACTIVE;
      vs_raw_q      <= ~SYNC_ACTIVE;
    end else begin
      primed_q      <= primed_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      blank_q       <= blank_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      hs_raw_q      <= hs_raw_d;
      vs_raw_q      <= vs_raw_d;
    end
  end

  vga_sync_delay #(
    .Depth (SYNC_DELAY),
    .Width (2)
  ) u_sync_delay (
    .clk_i  (vga_clk),
    .rst_ni (reset_n),
    .d_i    ({hs_raw_q, vs_raw_q}),
    .q_o    (sync_dly)
  );

  assign DrawX       = hc_q;
  assign DrawY       = vc_q;
  assign blank       = blank_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign hs          = sync_dly[1];
  assign vs          = sync_dly[0];

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  // Count frame wraps only; the priming edge's frame_start is not a wrap.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (primed_q && frame_start_d) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  // Frame counter register.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance and a shrunk-timing instance
// driven by one reset, checked every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  localparam int unsigned FD      = 2;
  localparam int unsigned SD      = 1;
  localparam int unsigned SH_VIS  = 16;
  localparam int unsigned SH_FP   = 4;
  localparam int unsigned SH_SYNC = 6;
  localparam int unsigned SH_BP   = 5;
  localparam int unsigned SV_VIS  = 12;
  localparam int unsigned SV_FP   = 2;
  localparam int unsigned SV_SYNC = 2;
  localparam int unsigned SV_BP   = 3;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        blank;
    logic        ls;
    logic        fs;
    logic        hs;
    logic        vs;
    logic [15:0] fc;
  } exp_t;

  logic       vga_clk = 1'b0;
  logic       reset_n = 1'b1;
  logic [9:0] fx, fy, sx, sy;
  logic       fb, fhs, fvs, fls, ffs;
  logic       sb, shs, svs, sls, sfs;
`ifdef VGA_FRAME_CNT_EN
  logic [15:0] ffc, sfc;
`endif

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned n_edges  = 0;
  int unsigned k        = 0;

  vga_timing_gen #(
    .SYNC_DELAY (FD)
  ) dut (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (fx),
    .DrawY       (fy),
    .blank       (fb),
    .hs          (fhs),
    .vs          (fvs),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt   (ffc),
`endif
    .line_start  (fls),
    .frame_start (ffs)
  );

  vga_timing_gen #(
    .H_VISIBLE  (SH_VIS),
    .H_FP       (SH_FP),
    .H_SYNC     (SH_SYNC),
    .H_BP       (SH_BP),
    .V_VISIBLE  (SV_VIS),
    .V_FP       (SV_FP),
    .V_SYNC     (SV_SYNC),
    .V_BP       (SV_BP),
    .SYNC_DELAY (SD)
  ) dut_small (
    .vga_clk     (vga_clk),
    .reset_n     (reset_n),
    .DrawX       (sx),
    .DrawY       (sy),
    .blank       (sb),
    .hs          (shs),
    .vs          (svs),
`ifdef VGA_FRAME_CNT_EN
    .frame_cnt   (sfc),
`endif
    .line_start  (sls),
    .frame_start (sfs)
  );

  always #5 vga_clk = ~vga_clk;

  // Number of rising edges seen with reset released; 0 while in reset.
  always @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) n_edges <= 0;
    else          n_edges <= n_edges + 1;
  end

  // Raster model: edge n >= 1 presents linear pixel index n-1; syncs look at
  // index n-1-d, and anything before index 0 is the idle (high) level.
  function automatic exp_t model(input int unsigned n, input int unsigned hv,
                                 input int unsigned hfp, input int unsigned hsy,
                                 input int unsigned hbp, input int unsigned vv,
                                 input int unsigned vfp, input int unsigned vsy,
                                 input int unsigned vbp, input int unsigned d);
    exp_t   e;
    longint ht, vt, p, q, x, y, qx, qy;
    ht = longint'(hv + hfp + hsy + hbp);
    vt = longint'(vv + vfp + vsy + vbp);
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    if (n == 0) return e;
    p = longint'(n) - 1;
    x = p % ht;
    y = (p / ht) % vt;
    e.x     = 10'(x);
    e.y     = 10'(y);
    e.blank = (x < longint'(hv)) && (y < longint'(vv));
    e.ls    = (x == 0);
    e.fs    = (x == 0) && (y == 0);
    q = p - longint'(d);
    if (q >= 0) begin
      qx = q % ht;
      qy = (q / ht) % vt;
      e.hs = !((qx >= longint'(hv + hfp)) && (qx < longint'(hv + hfp + hsy)));
      e.vs = !((qy >= longint'(vv + vfp)) && (qy < longint'(vv + vfp + vsy)));
    end
    e.fc = 16'((p / (ht * vt)) % 65536);
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t, edge %0d)", name, act, exp, $time,
               n_edges);
    end
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic [9:0] x, input logic [9:0] y,
                     input logic b, input logic ls, input logic fs, input logic hs,
                     input logic vs);
    chk({tag, " DrawX"}, 32'(x), 32'(e.x));
    chk({tag, " DrawY"}, 32'(y), 32'(e.y));
    chk({tag, " blank"}, 32'(b), 32'(e.blank));
    chk({tag, " line_start"}, 32'(ls), 32'(e.ls));
    chk({tag, " frame_start"}, 32'(fs), 32'(e.fs));
    chk({tag, " hs"}, 32'(hs), 32'(e.hs));
    chk({tag, " vs"}, 32'(vs), 32'(e.vs));
  endtask

  int unsigned f_ls_last, s_ls_last, s_fs_last, s_blank_cnt;
  int unsigned f_hs_run, s_hs_run, s_vs_run;
  bit          f_ls_ok, s_ls_ok, s_fs_ok;

  // Per-cycle compare against the model, plus interval/width monitors.
  always @(negedge vga_clk) begin
    exp_t ef, es;
    ef = model(n_edges, 640, 16, 96, 48, 480, 10, 2, 33, FD);
    es = model(n_edges, SH_VIS, SH_FP, SH_SYNC, SH_BP, SV_VIS, SV_FP, SV_SYNC, SV_BP, SD);
    cmp("full", ef, fx, fy, fb, fls, ffs, fhs, fvs);
    cmp("small", es, sx, sy, sb, sls, sfs, shs, svs);
`ifdef VGA_FRAME_CNT_EN
    chk("full frame_cnt", 32'(ffc), 32'(ef.fc));
    chk("small frame_cnt", 32'(sfc), 32'(es.fc));
`endif
    if (!reset_n) begin
      f_ls_ok = 0; s_ls_ok = 0; s_fs_ok = 0; s_blank_cnt = 0;
      f_hs_run = 0; s_hs_run = 0; s_vs_run = 0;
    end else begin
      if (fls) begin
        if (f_ls_ok) chk("full line_start spacing", n_edges - f_ls_last, 800);
        f_ls_last = n_edges; f_ls_ok = 1;
      end
      if (sls) begin
        if (s_ls_ok) chk("small line_start spacing", n_edges - s_ls_last, 31);
        s_ls_last = n_edges; s_ls_ok = 1;
      end
      if (sfs) begin
        if (s_fs_ok) begin
          chk("small frame_start spacing", n_edges - s_fs_last, 589);
          chk("small blank count per frame", s_blank_cnt, 192);
        end
        s_fs_last = n_edges; s_fs_ok = 1; s_blank_cnt = 0;
      end
      if (sb && s_fs_ok) s_blank_cnt++;
      if (!fhs) f_hs_run++;
      else if (f_hs_run != 0) begin chk("full hs low width", f_hs_run, 96); f_hs_run = 0; end
      if (!shs) s_hs_run++;
      else if (s_hs_run != 0) begin chk("small hs low width", s_hs_run, 6); s_hs_run = 0; end
      if (!svs) s_vs_run++;
      else if (s_vs_run != 0) begin chk("small vs low width", s_vs_run, 62); s_vs_run = 0; end
    end
  end

  task automatic adv(input int unsigned to);
    while (k < to) begin
      @(negedge vga_clk);
      k++;
    end
  endtask

  initial begin
    int unsigned hold, run, i;
    #1 reset_n = 1'b0;
    repeat (3) @(negedge vga_clk);
    chk("reset DrawX", 32'(fx), 0);
    chk("reset blank", 32'(fb), 0);
    chk("reset hs", 32'(fhs), 1);
    chk("reset vs", 32'(fvs), 1);
    chk("reset frame_start", 32'(sfs), 0);
    #2 reset_n = 1'b1;
    k = 0;
    adv(1);
    chk("first DrawX", 32'(fx), 0);
    chk("first DrawY", 32'(fy), 0);
    chk("first blank", 32'(fb), 1);
    chk("first line_start", 32'(fls), 1);
    chk("first frame_start", 32'(ffs), 1);
    chk("small first frame_start", 32'(sfs), 1);
    adv(435);  chk("small vs before pulse", 32'(svs), 1);
    adv(436);  chk("small vs pulse start", 32'(svs), 0);
    adv(589);  chk("small last DrawX", 32'(sx), 30);
    chk("small last DrawY", 32'(sy), 18);
    adv(590);  chk("small wrap DrawX", 32'(sx), 0);
    chk("small wrap DrawY", 32'(sy), 0);
    chk("small wrap frame_start", 32'(sfs), 1);
    chk("small wrap vs", 32'(svs), 1);
`ifdef VGA_FRAME_CNT_EN
    chk("small frame_cnt frame2", 32'(sfc), 1);
`endif
    adv(640);  chk("DrawX 639", 32'(fx), 639);
    chk("blank at 639", 32'(fb), 1);
    adv(641);  chk("DrawX 640", 32'(fx), 640);
    chk("blank at 640", 32'(fb), 0);
    adv(658);  chk("hs before delayed pulse", 32'(fhs), 1);
    adv(659);  chk("hs delayed pulse start", 32'(fhs), 0);
    adv(754);  chk("hs delayed pulse last", 32'(fhs), 0);
    adv(755);  chk("hs after delayed pulse", 32'(fhs), 1);
`ifdef VGA_FRAME_CNT_EN
    adv(1179); chk("small frame_cnt frame3", 32'(sfc), 2);
`endif
    adv(2500);

    // Random asynchronous resets at random phases and lengths.
    for (int r = 0; r < 3; r++) begin
      @(negedge vga_clk);
      #($urandom_range(1, 4));
      reset_n = 1'b0;
      #1;
      chk("async reset hs", 32'(fhs), 1);
      chk("async reset vs", 32'(fvs), 1);
      chk("async reset DrawX", 32'(fx), 0);
      chk("async reset small DrawY", 32'(sy), 0);
      hold = $urandom_range(1, 5);
      repeat (hold) @(negedge vga_clk);
      #($urandom_range(1, 3));
      reset_n = 1'b1;
      run = $urandom_range(100, 1500);
      repeat (run) @(negedge vga_clk);
    end

    // Reset in the middle of an hsync pulse.
    i = 0;
    while (fx != 700 && i < 2000) begin
      @(negedge vga_clk);
      i++;
    end
    chk("reach DrawX 700", 32'(fx), 700);
    chk("hs low at DrawX 700", 32'(fhs), 0);
    #2 reset_n = 1'b0;
    #1;
    chk("mid-hsync reset hs", 32'(fhs), 1);
    chk("mid-hsync reset DrawX", 32'(fx), 0);
    repeat (2) @(negedge vga_clk);
    #2 reset_n = 1'b1;
    repeat (1000) @(negedge vga_clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
